// File: rtl/pad_seq_pkg.sv
// Shared types for the padding-layer sequencer: FSM states, layer descriptor, tail constant.
// No logic; desc_ok() screens a descriptor before it may enter the FIFO.
// Backpressure: n/a.
package pad_seq_pkg;

    localparam int unsigned PAD_TAIL_EXTRA = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_PRE,
        S_ROW,
        S_GAP,
        S_TAIL,
        S_DONE
    } pad_seq_state_t;

    typedef struct packed {
        logic [15:0] c;
        logic [15:0] w;
        logic        pad;
    } pad_desc_t;

    // A layer must have non-zero dimensions and a whole number of PE-wide beats.
    function automatic logic desc_ok(input pad_desc_t d, input int unsigned pe);
        logic [31:0] prod;
        prod = {16'd0, d.c} * {16'd0, d.w};
        return (d.c != 16'd0) && (d.w != 16'd0) && ((prod & (pe - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/pad_desc_fifo.sv
// Synchronous descriptor FIFO (DEPTH a power of two, >= 2); head is visible combinationally.
// Latency: one cycle push-to-visible. Push while full is dropped (drop_o) unless a pop
// happens in the same cycle, in which case both proceed and occupancy is unchanged.
module pad_desc_fifo
    import pad_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  pad_desc_t din_i,
    output pad_desc_t dout_o,
    output logic      full_o,
    output logic      empty_o,
    output logic      drop_o
);
    localparam int AW = $clog2(DEPTH);

    pad_desc_t        mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pad_layer_sequencer.sv
// Layer sequencer for the padding controller: queues descriptors, pulses start, gates rows with pad gaps.
// Latency: go -> pad_start 2 cycles; up_ready is a pure state decode (ROW only), never from up_valid.
// Optional PAD_SEQ_PERF_EN adds perf_cycles/perf_stalls counters; upstream stalls in ROW just hold the beat count.
module pad_layer_sequencer
    import pad_seq_pkg::*;
#(
    parameter int PE    = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_wr,
    input  logic [15:0]     cfg_c,
    input  logic [15:0]     cfg_w,
    input  logic            cfg_pad,
    output logic            cfg_full,
    input  logic            go,
    input  logic            up_valid,
    input  logic [PE*8-1:0] up_data,
    output logic            up_ready,
    output logic            pad_start,
    output logic            pad_valid,
    output logic [PE*8-1:0] pad_data,
    output logic [15:0]     pad_ofm_c,
    output logic [15:0]     pad_ofm_w,
    output logic            pad_padding,
    output logic            busy,
    output logic            layer_done,
    output logic [7:0]      layer_idx,
    output logic            err
`ifdef PAD_SEQ_PERF_EN
    ,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_stalls
`endif
);
    localparam int SH = $clog2(PE);

    pad_seq_state_t state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    beat_q, beat_d;
    logic [15:0]    row_q, row_d;
    logic [7:0]     idx_q, idx_d;
    logic           err_q, err_d;
    logic [31:0]    bpr_q, gap_q, pre_q, tail_q;
    logic [31:0]    bpr_d, gap_d, pre_d, tail_d;
    logic [15:0]    c_q, w_q;
    logic           pad_q;

    pad_desc_t      cfg_desc, head;
    logic           desc_good, push, pop;
    logic           fifo_full, fifo_empty, fifo_drop;
    logic [31:0]    cw_prod;
    logic [16:0]    w_ext;
    logic [33:0]    pre_prod;

    assign cfg_desc  = '{c: cfg_c, w: cfg_w, pad: cfg_pad};
    assign desc_good = desc_ok(cfg_desc, PE);
    assign push      = cfg_wr && desc_good;

    pad_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (cfg_desc),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    // Derived per-layer values from the FIFO head; only captured in LOAD. /PE is a shift.
    always_comb begin
        cw_prod  = {16'd0, head.c} * {16'd0, head.w};
        w_ext    = {1'b0, head.w} + (head.pad ? 17'd2 : 17'd0);
        pre_prod = {18'd0, head.c} * {17'd0, w_ext};
        bpr_d    = cw_prod >> SH;
        gap_d    = ((head.pad ? {15'd0, head.c, 1'b0} : 32'd0) >> SH) + 32'd1;
        pre_d    = 32'(pre_prod >> SH);
        tail_d   = pre_d + 32'(PAD_TAIL_EXTRA);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        row_d   = row_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        err_d   = err_q || fifo_drop || (cfg_wr && !desc_good);
        case (state_q)
            S_IDLE:  if (go && !fifo_empty) state_d = S_LOAD;
            S_LOAD: begin
                pop     = 1'b1;
                cnt_d   = '0;
                beat_d  = '0;
                row_d   = '0;
                state_d = S_START;
            end
            S_START: state_d = S_PRE;
            S_PRE: begin
                if (cnt_q == pre_q - 32'd1) begin
                    cnt_d   = '0;
                    state_d = S_ROW;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ROW: begin
                if (up_valid) begin
                    if (beat_q == bpr_q - 32'd1) begin
                        beat_d  = '0;
                        row_d   = row_q + 16'd1;
                        state_d = (row_q + 16'd1 == w_q) ? S_TAIL : S_GAP;
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == gap_q - 32'd1) begin
                    cnt_d   = '0;
                    state_d = S_ROW;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_TAIL: begin
                if (cnt_q == tail_q - 32'd1) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 8'd1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // Back-to-back layers skip IDLE so the next LOAD follows DONE directly.
            S_DONE:  state_d = (go && !fifo_empty) ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            bpr_q   <= '0;
            gap_q   <= '0;
            pre_q   <= '0;
            tail_q  <= '0;
            c_q     <= '0;
            w_q     <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (state_q == S_LOAD) begin
                bpr_q  <= bpr_d;
                gap_q  <= gap_d;
                pre_q  <= pre_d;
                tail_q <= tail_d;
                c_q    <= head.c;
                w_q    <= head.w;
                pad_q  <= head.pad;
            end
        end
    end

`ifdef PAD_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == S_LOAD) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (state_q inside {S_START, S_PRE, S_ROW, S_GAP, S_TAIL}) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (state_q == S_ROW && !up_valid) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

    assign cfg_full    = fifo_full;
    assign up_ready    = (state_q == S_ROW);
    assign pad_start   = (state_q == S_START);
    assign pad_valid   = up_valid && up_ready;
    assign pad_data    = up_data;
    assign pad_ofm_c   = c_q;
    assign pad_ofm_w   = w_q;
    assign pad_padding = pad_q;
    assign busy        = (state_q != S_IDLE);
    assign layer_done  = (state_q == S_DONE);
    assign layer_idx   = idx_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pad_layer_sequencer.sv
// Scoreboard bench for pad_layer_sequencer: directed layers push expected starts/beats/completions,
// a negedge monitor pops and compares whenever the DUT presents pad_start, pad_valid or layer_done.
`timescale 1ns/1ps
module tb_pad_layer_sequencer;

    localparam int PE    = 16;
    localparam int DEPTH = 4;
    localparam int DW    = PE * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr;
    logic [15:0]   cfg_c, cfg_w;
    logic          cfg_pad;
    logic          cfg_full;
    logic          go;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          up_ready;
    logic          pad_start, pad_valid;
    logic [DW-1:0] pad_data;
    logic [15:0]   pad_ofm_c, pad_ofm_w;
    logic          pad_padding, busy, layer_done, err;
    logic [7:0]    layer_idx;
`ifdef PAD_SEQ_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    pad_layer_sequencer #(.PE(PE), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_c       (cfg_c),
        .cfg_w       (cfg_w),
        .cfg_pad     (cfg_pad),
        .cfg_full    (cfg_full),
        .go          (go),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_ready    (up_ready),
        .pad_start   (pad_start),
        .pad_valid   (pad_valid),
        .pad_data    (pad_data),
        .pad_ofm_c   (pad_ofm_c),
        .pad_ofm_w   (pad_ofm_w),
        .pad_padding (pad_padding),
        .busy        (busy),
        .layer_done  (layer_done),
        .layer_idx   (layer_idx),
        .err         (err)
`ifdef PAD_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } beat_exp_t;

    typedef struct {
        int cyc;
        int idx;
        int c;
        int w;
        int pad;
        int pcyc;
        int pstall;
    } done_exp_t;

    int        exp_start_q[$];
    beat_exp_t exp_beat_q[$];
    done_exp_t exp_done_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int tag, input int i);
        logic [31:0] v;
        v = (32'(tag) << 16) | 32'(i);
        return {4{v}};
    endfunction

    // Upstream source: a numbered beat stream, optionally withholding valid for a few cycles.
    int   drv_tag = 0, drv_idx = 0, drv_total = 0, stall_at = -1, stall_left = 0;
    logic drv_acc;

    initial begin
        up_valid = 1'b0;
        up_data  = '0;
        drv_acc  = 1'b0;
        forever begin
            @(negedge clk);
            drv_acc = up_valid && up_ready;
            @(posedge clk);
            #1;
            if (drv_acc) drv_idx++;
            if (stall_left > 0 && drv_idx == stall_at) begin
                up_valid = 1'b0;
                stall_left--;
            end else begin
                up_valid = (drv_idx < drv_total);
            end
            up_data = pat(drv_tag, drv_idx);
        end
    end

    always @(negedge clk) begin
        beat_exp_t be;
        done_exp_t de;
        int        es;
        if (rst_n) begin
            if (pad_start) begin
                chk("start_expected", int'(exp_start_q.size() > 0), 1);
                if (exp_start_q.size() > 0) begin
                    es = exp_start_q.pop_front();
                    chk("start_cycle", cyc, es);
                end
            end
            if (pad_valid) begin
                chk("beat_expected", int'(exp_beat_q.size() > 0), 1);
                if (exp_beat_q.size() > 0) begin
                    be = exp_beat_q.pop_front();
                    chk_dat("beat_data", pad_data, be.dat);
                    chk("beat_cycle", cyc, be.cyc);
                end
            end
            if (layer_done) begin
                chk("done_expected", int'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    de = exp_done_q.pop_front();
                    chk("done_cycle", cyc, de.cyc);
                    chk("layer_idx", int'(layer_idx), de.idx);
                    chk("ofm_c", int'(pad_ofm_c), de.c);
                    chk("ofm_w", int'(pad_ofm_w), de.w);
                    chk("padding", int'(pad_padding), de.pad);
                    chk("busy_at_done", int'(busy), 1);
`ifdef PAD_SEQ_PERF_EN
                    chk("perf_cycles", int'(perf_cycles), de.pcyc);
                    chk("perf_stalls", int'(perf_stalls), de.pstall);
`endif
                end
            end
        end
    end

    // n is the IDLE cycle in which go is sampled (or the previous layer's DONE when back-to-back).
    task automatic expect_layer(input int n, input int c, input int w, input int pad,
                                input int bpr, input int gap, input int pre, input int tail,
                                input int idx, input int tag, inout int bidx,
                                input int s_at, input int s_len, output int done_cyc);
        beat_exp_t be;
        done_exp_t de;
        int        extra;
        exp_start_q.push_back(n + 2);
        for (int r = 0; r < w; r++) begin
            for (int b = 0; b < bpr; b++) begin
                extra  = (s_at >= 0 && bidx >= s_at) ? s_len : 0;
                be.dat = pat(tag, bidx);
                be.cyc = n + 3 + pre + r * (bpr + gap) + b + extra;
                exp_beat_q.push_back(be);
                bidx++;
            end
        end
        extra     = (s_at >= 0) ? s_len : 0;
        done_cyc  = n + 3 + pre + w * bpr + (w - 1) * gap + tail + extra;
        de.cyc    = done_cyc;
        de.idx    = idx;
        de.c      = c;
        de.w      = w;
        de.pad    = pad;
        de.pcyc   = done_cyc - n - 2;
        de.pstall = extra;
        exp_done_q.push_back(de);
    endtask

    task automatic push_desc(input int c, input int w, input int pad);
        @(posedge clk);
        #1;
        cfg_wr  = 1'b1;
        cfg_c   = 16'(c);
        cfg_w   = 16'(w);
        cfg_pad = 1'(pad);
        @(posedge clk);
        #1;
        cfg_wr  = 1'b0;
    endtask

    task automatic wait_layers(input string name, input int budget);
        int k = 0;
        while (exp_done_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_done_in_time"}, int'(exp_done_q.size() == 0), 1);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_beats_left"}, exp_beat_q.size(), 0);
        chk({name, "_starts_left"}, exp_start_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pad_start"},  int'(pad_start), 0);
        chk({tag, "_pad_valid"},  int'(pad_valid), 0);
        chk({tag, "_up_ready"},   int'(up_ready), 0);
        chk({tag, "_busy"},       int'(busy), 0);
        chk({tag, "_layer_done"}, int'(layer_done), 0);
        chk({tag, "_layer_idx"},  int'(layer_idx), 0);
        chk({tag, "_err"},        int'(err), 0);
        chk({tag, "_cfg_full"},   int'(cfg_full), 0);
        chk({tag, "_ofm_c"},      int'(pad_ofm_c), 0);
        chk({tag, "_ofm_w"},      int'(pad_ofm_w), 0);
        chk({tag, "_padding"},    int'(pad_padding), 0);
`ifdef PAD_SEQ_PERF_EN
        chk({tag, "_perf_cycles"}, int'(perf_cycles), 0);
        chk({tag, "_perf_stalls"}, int'(perf_stalls), 0);
`endif
    endtask

    task automatic set_stream(input int tag, input int total, input int s_at, input int s_len);
        @(negedge clk);
        drv_tag    = tag;
        drv_idx    = 0;
        drv_total  = total;
        stall_at   = s_at;
        stall_left = s_len;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, bidx, k;
        cfg_wr = 1'b0; cfg_c = '0; cfg_w = '0; cfg_pad = 1'b0; go = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // C=16 W=4 pad=1: BPR=4 GAP=3 PRE=6 TAIL=10, done 44 cycles after the go cycle.
        set_stream(1, 16, -1, 0);
        push_desc(16, 4, 1);
        n = cyc; go = 1'b1; bidx = 0;
        expect_layer(n, 16, 4, 1, 4, 3, 6, 10, 1, 1, bidx, -1, 0, d);
        @(posedge clk); #1; go = 1'b0;
        wait_layers("t1", 200);
        chk("t1_err", int'(err), 0);
        chk("t1_cfg_full", int'(cfg_full), 0);

        // C=32 W=2 pad=0: BPR=4 GAP=1 PRE=4 TAIL=8, 25-cycle layer.
        set_stream(2, 8, -1, 0);
        push_desc(32, 2, 0);
        n = cyc; go = 1'b1; bidx = 0;
        expect_layer(n, 32, 2, 0, 4, 1, 4, 8, 2, 2, bidx, -1, 0, d);
        @(posedge clk); #1; go = 1'b0;
        wait_layers("t2", 200);

        // Same as the first layer with a 5-cycle upstream stall before beat 2.
        set_stream(3, 16, 2, 5);
        push_desc(16, 4, 1);
        n = cyc; go = 1'b1; bidx = 0;
        expect_layer(n, 16, 4, 1, 4, 3, 6, 10, 3, 3, bidx, 2, 5, d);
        @(posedge clk); #1; go = 1'b0;
        wait_layers("t3", 200);
        chk("t3_err", int'(err), 0);

        // C=8 W=1: C*W not a multiple of PE, rejected at push.
        set_stream(4, 0, -1, 0);
        push_desc(8, 1, 0);
        chk("t4_err", int'(err), 1);
        chk("t4_cfg_full", int'(cfg_full), 0);
        go = 1'b1;
        repeat (12) @(posedge clk);
        #1; go = 1'b0;
        chk("t4_busy", int'(busy), 0);

        // Reset asserted while a ROW beat is on the bus.
        set_stream(5, 16, -1, 0);
        push_desc(16, 4, 1);
        n = cyc; go = 1'b1; bidx = 0;
        expect_layer(n, 16, 4, 1, 4, 3, 6, 10, 4, 5, bidx, -1, 0, d);
        @(posedge clk); #1; go = 1'b0;
        k = 0;
        while (!pad_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_row_reached", int'(pad_valid), 1);
        #2;
        rst_n = 1'b0;
        drv_total = 0;
        #1;
        chk_zero("t5_reset");
        exp_start_q.delete();
        exp_beat_q.delete();
        exp_done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        go = 1'b1;
        repeat (12) @(posedge clk);
        #1; go = 1'b0;
        chk("t5_busy_after", int'(busy), 0);
        chk("t5_idx_after", int'(layer_idx), 0);

        // Four descriptors fill the FIFO, the fifth is dropped; four back-to-back layers follow.
        set_stream(6, 10, -1, 0);
        push_desc(16, 1, 0);
        push_desc(32, 1, 0);
        push_desc(48, 1, 0);
        chk("t6_full_after3", int'(cfg_full), 0);
        push_desc(64, 1, 0);
        chk("t6_full_after4", int'(cfg_full), 1);
        chk("t6_err_before", int'(err), 0);
        push_desc(80, 1, 0);
        chk("t6_err_after5", int'(err), 1);
        chk("t6_full_after5", int'(cfg_full), 1);
        n = cyc; go = 1'b1; bidx = 0;
        expect_layer(n, 16, 1, 0, 1, 1, 1, 5, 1, 6, bidx, -1, 0, d);
        n = d;
        expect_layer(n, 32, 1, 0, 2, 1, 2, 6, 2, 6, bidx, -1, 0, d);
        n = d;
        expect_layer(n, 48, 1, 0, 3, 1, 3, 7, 3, 6, bidx, -1, 0, d);
        n = d;
        expect_layer(n, 64, 1, 0, 4, 1, 4, 8, 4, 6, bidx, -1, 0, d);
        wait_layers("t6", 400);
        repeat (10) @(posedge clk);
        #1; go = 1'b0;
        chk("t6_layer_idx", int'(layer_idx), 4);
        chk("t6_cfg_full_end", int'(cfg_full), 0);
        chk("t6_busy_end", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_layer_sequencer.md
# pad_layer_sequencer

Sequences the padding write controller layer by layer. Layer descriptors (OFM_C, OFM_W, padding) are queued in a small FIFO. For each layer the block pulses `start`, drives the static configuration, and gates the upstream PE-wide data stream into rows. Between rows it inserts idle gaps so the padding controller can write top, left/right and bottom padding. It sits between the PE array output stage and the padding controller, and reports per-layer completion to the top-level layer scheduler.

## Interface
- `PE`, 16: bytes per data beat; must be a power of two.
- `DEPTH`, 4: descriptor FIFO entries; must be a power of two.
- `clk`  in  1  — clock.
- `rst_n`  in  1  — asynchronous active-low reset.
- `cfg_wr`  in  1  — push a descriptor.
- `cfg_c`  in  16  — OFM_C of the descriptor.
- `cfg_w`  in  16  — OFM_W of the descriptor; also the row count (square map).
- `cfg_pad`  in  1  — padding of the descriptor (0 or 1).
- `cfg_full`  out  1  — FIFO full.
- `go`  in  1  — level; enables popping the next descriptor.
- `up_valid`  in  1  — upstream beat available.
- `up_data`  in  PE*8  — upstream beat.
- `up_ready`  out  1  — beat accepted when `up_valid && up_ready`.
- `pad_start`  out  1  — one-cycle start pulse to the padding controller.
- `pad_valid`  out  1  — equals `up_valid && up_ready`.
- `pad_data`  out  PE*8  — equals `up_data`, unregistered.
- `pad_ofm_c`, `pad_ofm_w`  out  16  — held configuration.
- `pad_padding`  out  1  — held configuration.
- `busy`  out  1  — high from LOAD through DONE.
- `layer_done`  out  1  — one-cycle pulse at the end of a layer.
- `layer_idx`  out  8  — completed-layer count; wraps at 255→0.
- `err`  out  1  — sticky; cleared only by reset.

## Operation
- Derived values are latched in LOAD, 32-bit unsigned, with `/PE` implemented as a shift:
  - BPR = C*W/PE
  - GAP = 2*pad*C/PE + 1
  - PRE = C*(W+2*pad)/PE
  - TAIL = PRE + 4
- States:
  - IDLE → LOAD when `go` is high and the FIFO is non-empty.
  - LOAD: pop the descriptor, latch config and derived values. → START.
  - START: `pad_start`=1 for one cycle. → PRE.
  - PRE: count PRE cycles with `up_ready`=0. → ROW.
  - ROW: `up_ready`=1. Count accepted beats; on the BPR-th beat increment the row count. If rows == W → TAIL, else → GAP.
  - GAP: `up_ready`=0 for GAP cycles. → ROW.
  - TAIL: `up_ready`=0 for TAIL cycles. → DONE.
  - DONE: pulse `layer_done`, increment `layer_idx`. → IDLE.
- An upstream stall (`up_valid`=0) in ROW holds the beat counter; no timeout.
- Descriptor checks:
  - `cfg_wr` while full: the descriptor is dropped and `err` is set.
  - A descriptor with C=0, W=0, or C*W not a multiple of PE is rejected at push and sets `err`.
- A push and a pop in the same cycle while full is legal; occupancy is unchanged.
- `go` deasserted mid-layer does not abort the layer; it only blocks the next LOAD.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE.
- `pad_*` configuration outputs are registered in LOAD and stable until the next LOAD.
- `up_ready` is a registered state decode; no combinational path from `up_valid`.
- Latency from `go` with a non-empty FIFO to `pad_start` is 2 cycles (IDLE→LOAD→START).
- The first beat is accepted no earlier than PRE+1 cycles after `pad_start`.
- Layer cycle count with no stalls: 3 + PRE + W*BPR + (W−1)*GAP + TAIL + 1.
- Back-to-back layers: the next LOAD occurs the cycle after DONE.
- Reset mid-layer: immediate return to IDLE, FIFO flushed, no `layer_done`.

## Configuration
- `PAD_SEQ_PERF_EN` defined:
  - Adds outputs `perf_cycles` [31:0] and `perf_stalls` [31:0].
  - Both clear in LOAD.
  - `perf_cycles` counts every cycle from START through TAIL.
  - `perf_stalls` counts ROW cycles with `up_valid`=0.
  - Both hold after DONE.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `pad_seq_pkg`:
  - state enum `pad_seq_state_t`
  - descriptor struct `pad_desc_t` {c, w, pad}
  - constant `PAD_TAIL_EXTRA = 4`
- One sub-module, `pad_desc_fifo`: synchronous FIFO of `pad_desc_t` with full/empty flags and a same-cycle push/pop rule.

## Test plan
- Single layer, C=16, W=4, pad=1, PE=16:
  - Derived values: BPR=4, GAP=3, PRE=6, TAIL=10.
  - Response: `pad_start` 2 cycles after `go`; 16 beats in 4 rows with 3-cycle gaps; `layer_done` at cycle 3+6+16+9+10+1 = 45; `layer_idx`=1.
- pad=0, C=32, W=2: BPR=4, GAP=1, PRE=4, TAIL=8. Response: 8 beats, one gap cycle, `layer_done` after 25 cycles.
- Upstream drops `up_valid` for 5 cycles mid-row → beat count holds; `layer_done` is 5 cycles later than the stall-free case; `perf_stalls`=5 with PERF_EN.
- Push 5 descriptors with DEPTH=4 → `cfg_full`=1 after the 4th push; 5th dropped; `err`=1; exactly 4 layers complete.
- Descriptor C=8, W=1, PE=16 (C*W not a multiple of PE) → rejected; `err`=1; FIFO stays empty; no `pad_start`.
- `rst_n` low during a ROW beat → all outputs 0 immediately; after release, `go` with an empty FIFO produces no `pad_start`.
